iq_alloc: RTL
=============

# iq_alloc

Allocation stage for the 16-entry centralized issue queue (CIQ). It sits between rename and the CIQ and tracks which CIQ entries are free. Each cycle it hands out up to INSTR_NUM free entry addresses (`free_addr`/`free_valid`) and stamps every allocated instruction with a wrapping age. Entries return to the free pool when the arbiter grants them for issue.

## Interface
- `INSTR_NUM`, 4, rename width (instructions per cycle)
- `ISSUE_NUM`, 4, arbiter grants per cycle
- `CIQ_DEPTH`, 16, CIQ entries
- `AGE`, 5, age field width

- `clk` in 1, clock
- `rst` in 1, synchronous, active-high reset
- `flush` in 1, pipeline flush: frees every entry
- `instr_valid` in INSTR_NUM, rename slot valid; must be contiguous from bit 0
- `alloc_ready` out 1, all valid slots fit this cycle
- `free_addr` out [3:0] x INSTR_NUM, CIQ address for slot i
- `free_valid` out INSTR_NUM, slot i written to CIQ this cycle
- `age` out [AGE-1:0] x INSTR_NUM, age for slot i
- `arbit_addr` in [3:0] x ISSUE_NUM, granted CIQ addresses
- `arbit_grant` in ISSUE_NUM, grant j valid
- `iq_count` out 5, occupied entries (registered)
- `iq_full` out 1, `iq_count == CIQ_DEPTH`

## Operation
- State: `free_vec[CIQ_DEPTH-1:0]` (1 = free), `age_cnt[AGE-1:0]`, `iq_count`.
- Search: find the INSTR_NUM lowest-index free entries in the search vector. Slot i gets the i-th lowest free entry. `free_addr` is don't-care when `free_valid[i]=0`.
- Allocation is all-or-nothing: `alloc_ready = popcount(search) >= popcount(instr_valid)`.
- Fire condition: `alloc_ready & ~flush & ~rst`. When it holds, `free_valid = instr_valid`. Otherwise `free_valid = 0`; rename holds its slots and retries.
- `age[i] = age_cnt + i` (mod 2^AGE). On fire, `age_cnt += popcount(instr_valid)`, wrapping.
- Next state of `free_vec`: clear bits for fired slots, set bits for each `arbit_addr[j]` with `arbit_grant[j]`.
- Duplicate grant addresses, or a grant on an entry that is already free, are idempotent.
- `iq_count` next value is `CIQ_DEPTH - popcount(next free_vec)`. It never underflows.
- Flush: next `free_vec` is all ones, `age_cnt = 0`, no allocation that cycle. Flush overrides any grants.
- `instr_valid` all zero: `alloc_ready=1`, nothing fires.

## Timing
- Reset values: `free_vec` all ones, `age_cnt 0`, `iq_count 0`, `iq_full 0`. While `rst` is high, `free_valid 0` and `alloc_ready 0`.
- `free_addr`, `free_valid`, `alloc_ready` and `age` are combinational from registered state and `instr_valid`, so allocation takes zero cycles. The CIQ captures the write at the same edge that updates `free_vec`.
- A grant in cycle N frees the entry at edge N→N+1. The entry is allocatable in cycle N+1, unless the bypass below is enabled.
- Reset or flush asserted mid-stream takes effect at the next edge. No partial allocation ever fires in that cycle.

## Configuration
- `IQ_ALLOC_BYPASS_EN` defined: search vector = `free_vec | granted_this_cycle`. An entry granted in cycle N can be reallocated in cycle N. Clear takes priority over set for fired slots.
- Not defined: search vector = `free_vec`, giving a one-cycle reuse bubble and a shorter combinational path.

## Structure
- Package `iq_pkg`: `CIQ_DEPTH`, `INSTR_NUM`, `ISSUE_NUM`, `AGE`, `IQ_ADDR_W = $clog2(CIQ_DEPTH)`, and typedef `iq_addr_t`.
- Sub-module `iq_free_finder`: combinational "first INSTR_NUM set bits" finder returning addresses and a found mask. It is instantiated once.

## Test plan
- Reset, then `instr_valid=4'b1111` → `free_addr` 0,1,2,3; `free_valid=1111`; ages 0,1,2,3; next cycle `iq_count=4`.
- Allocate 4 per cycle for 4 cycles → `iq_full=1`, `alloc_ready=0`. Further `instr_valid=0001` → `free_valid=0000`.
- Full queue, grant addrs 5 and 9 in cycle N, `instr_valid=0011` → without bypass, fires in N+1 with `free_addr` 5,9; with `IQ_ALLOC_BYPASS_EN`, fires in N.
- 14 entries occupied, `instr_valid=0111` → `alloc_ready=0`, no fire, `iq_count` stays 14.
- `age_cnt=30`, `instr_valid=1111` → ages 30,31,0,1; `age_cnt` becomes 2.
- Flush asserted with `instr_valid=1111` and a grant on addr 3 → no fire; next cycle `iq_count=0`, `age_cnt=0`, full free vector.

Source files
------------

// File: rtl/iq_pkg.sv
// iq_pkg: shared sizing, address type and popcount helpers for the CIQ allocation stage.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package iq_pkg;

  localparam int CIQ_DEPTH = 16;  // CIQ entries
  localparam int INSTR_NUM = 4;   // rename width
  localparam int ISSUE_NUM = 4;   // arbiter grants per cycle
  localparam int AGE       = 5;   // age field width
  localparam int IQ_ADDR_W = $clog2(CIQ_DEPTH);
  localparam int CNT_W     = $clog2(CIQ_DEPTH + 1);  // holds 0..CIQ_DEPTH

  typedef logic [IQ_ADDR_W-1:0] iq_addr_t;

  // Number of set bits in an entry vector.
  function automatic logic [CNT_W-1:0] pop_entries(input logic [CIQ_DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < CIQ_DEPTH; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction

  // Number of set bits in a rename-slot vector.
  function automatic logic [CNT_W-1:0] pop_slots(input logic [INSTR_NUM-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < INSTR_NUM; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/iq_free_finder.sv
// iq_free_finder: returns the INSTR_NUM lowest-index set bits of a vector as addresses.
// Latency: purely combinational, zero cycles.
// Backpressure: none; o_count lets the caller decide whether a request fits.
// Ports:
//   i_vec   - candidate vector (1 = free entry)
//   o_addr  - packed addresses, slot s in bits [s*IQ_ADDR_W +: IQ_ADDR_W]; 0 when not found
//   o_found - slot s has a valid address
//   o_count - total number of set bits in i_vec (0..CIQ_DEPTH)
module iq_free_finder
  import iq_pkg::*;
(
  input  logic [CIQ_DEPTH-1:0]           i_vec,
  output logic [INSTR_NUM*IQ_ADDR_W-1:0] o_addr,
  output logic [INSTR_NUM-1:0]           o_found,
  output logic [CNT_W-1:0]               o_count
);

  // Walk the vector from bit 0 up; the running count of set bits seen so far
  // is the slot index that the current set bit lands in.
  always_comb begin
    o_addr  = '0;
    o_found = '0;
    o_count = '0;
    for (int b = 0; b < CIQ_DEPTH; b++) begin
      if (i_vec[b]) begin
        for (int s = 0; s < INSTR_NUM; s++) begin
          if (o_count == CNT_W'(s)) begin
            o_addr[s*IQ_ADDR_W +: IQ_ADDR_W] = IQ_ADDR_W'(b);
          end
        end
        o_count = o_count + CNT_W'(1);
      end
    end
    for (int s = 0; s < INSTR_NUM; s++) begin
      o_found[s] = (o_count > CNT_W'(s));
    end
  end

endmodule

// File: rtl/iq_alloc.sv
// iq_alloc: hands out free CIQ entry addresses to rename and stamps a wrapping age.
// Latency: allocation is combinational (zero cycles); free-pool/count update at the next edge.
// Backpressure: all-or-nothing; o_alloc_ready low means rename holds every slot and retries.
// Build option: define IQ_ALLOC_BYPASS_EN to let entries granted this cycle be reallocated
// in the same cycle (longer combinational path). Default: one-cycle reuse bubble.
// Ports:
//   i_clk, i_rst       - clock, synchronous active-high reset
//   i_flush            - frees every entry, clears age counter, blocks allocation this cycle
//   i_instr_valid      - rename slot valid (contiguous from bit 0)
//   o_alloc_ready      - all valid slots fit this cycle
//   o_free_addr        - packed CIQ address per slot, 4 bits each
//   o_free_valid       - slot written to CIQ this cycle
//   o_age              - packed age per slot, AGE bits each
//   i_arbit_addr       - packed granted CIQ addresses, 4 bits each
//   i_arbit_grant      - grant valid per issue port
//   o_iq_count         - occupied entries (registered)
//   o_iq_full          - o_iq_count == CIQ_DEPTH
module iq_alloc
  import iq_pkg::*;
(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_flush,
  input  logic [INSTR_NUM-1:0]           i_instr_valid,
  output logic                           o_alloc_ready,
  output logic [INSTR_NUM*IQ_ADDR_W-1:0] o_free_addr,
  output logic [INSTR_NUM-1:0]           o_free_valid,
  output logic [INSTR_NUM*AGE-1:0]       o_age,
  input  logic [ISSUE_NUM*IQ_ADDR_W-1:0] i_arbit_addr,
  input  logic [ISSUE_NUM-1:0]           i_arbit_grant,
  output logic [CNT_W-1:0]               o_iq_count,
  output logic                           o_iq_full
);

  logic [CIQ_DEPTH-1:0]           r_free_vec;
  logic [AGE-1:0]                 r_age_cnt;
  logic [CNT_W-1:0]               r_iq_count;

  logic [CIQ_DEPTH-1:0]           w_grant_vec;
  logic [CIQ_DEPTH-1:0]           w_search_vec;
  logic [CIQ_DEPTH-1:0]           w_alloc_vec;
  logic [CIQ_DEPTH-1:0]           w_free_nxt;
  logic [INSTR_NUM*IQ_ADDR_W-1:0] w_find_addr;
  logic [INSTR_NUM-1:0]           w_find_found;
  logic [CNT_W-1:0]               w_find_cnt;
  logic [CNT_W-1:0]               w_req_cnt;
  logic                           w_fit;
  logic                           w_fire;

  // Entries granted for issue this cycle; duplicates collapse onto one bit.
  always_comb begin
    w_grant_vec = '0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (i_arbit_grant[j]) begin
        w_grant_vec[i_arbit_addr[j*IQ_ADDR_W +: IQ_ADDR_W]] = 1'b1;
      end
    end
  end

`ifdef IQ_ALLOC_BYPASS_EN
  assign w_search_vec = r_free_vec | w_grant_vec;
`else
  assign w_search_vec = r_free_vec;
`endif

  iq_free_finder u_finder (
    .i_vec   (w_search_vec),
    .o_addr  (w_find_addr),
    .o_found (w_find_found),
    .o_count (w_find_cnt)
  );

  assign w_req_cnt = pop_slots(i_instr_valid);
  assign w_fit     = (w_find_cnt >= w_req_cnt);
  assign w_fire    = w_fit & ~i_flush & ~i_rst;

  assign o_alloc_ready = w_fit & ~i_rst;
  assign o_free_valid  = w_fire ? i_instr_valid : '0;
  assign o_free_addr   = w_find_addr;

  genvar gi;
  generate
    for (gi = 0; gi < INSTR_NUM; gi++) begin : g_age
      assign o_age[gi*AGE +: AGE] = r_age_cnt + AGE'(gi);
    end
  endgenerate

  // Entries consumed by the slots that fire this cycle.
  always_comb begin
    w_alloc_vec = '0;
    for (int i = 0; i < INSTR_NUM; i++) begin
      if (o_free_valid[i] && w_find_found[i]) begin
        w_alloc_vec[w_find_addr[i*IQ_ADDR_W +: IQ_ADDR_W]] = 1'b1;
      end
    end
  end

  // Clear beats set, so an entry granted and re-allocated in the same cycle
  // (bypass build) ends up occupied. Flush overrides everything.
  always_comb begin
    if (i_flush) begin
      w_free_nxt = '1;
    end else begin
      w_free_nxt = (r_free_vec | w_grant_vec) & ~w_alloc_vec;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_free_vec <= '1;
      r_age_cnt  <= '0;
      r_iq_count <= '0;
    end else begin
      r_free_vec <= w_free_nxt;
      r_iq_count <= CNT_W'(CIQ_DEPTH) - pop_entries(w_free_nxt);
      if (i_flush) begin
        r_age_cnt <= '0;
      end else if (w_fire) begin
        r_age_cnt <= r_age_cnt + AGE'(w_req_cnt);
      end
    end
  end

  assign o_iq_count = r_iq_count;
  assign o_iq_full  = (r_iq_count == CNT_W'(CIQ_DEPTH));

endmodule
